morse_transmitter: RTL and testbench

- Transmit side of the morse path: takes a 10-bit packed morse word (5 two-bit symbol slots, the format the player input accumulators produce) and replays it as a timed on/off signal for LED/buzzer output.
- Sits beside the player registers. Used to echo a player's entry or to present a challenge word.
- Single clock domain, no handshake beyond start/busy/done.

---
 rtl/morse_transmitter_pkg.sv | 24 ++
 rtl/morse_transmitter_if.sv | 26 ++
 rtl/morse_transmitter_timer.sv | 27 ++
 rtl/morse_transmitter.sv | 145 ++++++++++++++
 tb/tb_morse_transmitter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/morse_transmitter_pkg.sv
// Shared definitions for the morse transmit path: slot codes, FSM states,
// and a helper that tells whether any mark is left in a packed word.
package morse_transmitter_pkg;

    // Slot codes; 2'b10 is invalid and handled like NONE.
    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MARK,
        ST_GAP,
        ST_DONE
    } state_e;

    // Both DOT (01) and LINE (11) have bit 0 of their slot set; NONE and
    // the invalid code do not.
    function automatic logic has_mark(input logic [9:0] word);
        return word[8] | word[6] | word[4] | word[2] | word[0];
    endfunction

endpackage

// File: rtl/morse_transmitter_if.sv
// Start/busy/done handshake plus the packed code word and the mark output.
interface morse_transmitter_if;

    logic       start;
    logic [9:0] code;
    logic       signal_out;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output code,
        input  signal_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  code,
        output signal_out,
        output busy,
        output done
    );

endinterface

// File: rtl/morse_transmitter_timer.sv
// Loadable down-counter that stops at zero; shared by mark and gap timing.
module morse_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;

    // Count register: load wins, otherwise count down and hold at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/morse_transmitter.sv
// Replays a 10-bit packed morse word (slot 4 first) as timed marks and gaps.
module morse_transmitter
    import morse_transmitter_pkg::*;
#(
    parameter int unsigned DOT_TICKS  = 25000000,
    parameter int unsigned LINE_TICKS = 75000000,
    parameter int unsigned GAP_TICKS  = 25000000,
    parameter int unsigned CNT_W      = 27
) (
    input  logic               clock,
    input  logic               resetn,
    morse_transmitter_if.slave bus
);

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_TICKS - 1);
    localparam logic [CNT_W-1:0] LINE_LD = CNT_W'(LINE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS - 1);

    state_e           state_q, state_d;
    logic [9:0]       sh_q, sh_d;
    logic [2:0]       idx_q, idx_d;
    logic             sig_q, sig_d;
    logic             busy_q;
    logic             done_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;
    logic             fetch_now;

    morse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // A slot is examined in FETCH, and also on the last gap cycle so that
    // a mark following the gap starts without an extra low cycle.
    assign fetch_now = (state_q == ST_FETCH) ||
                       ((state_q == ST_GAP) && tmr_expired);

    // Next-state, shift register, slot index, timer load and mark level.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        idx_d    = idx_q;
        sig_d    = sig_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_IDLE: begin
                sig_d = 1'b0;
                if (bus.start) begin
                    sh_d    = bus.code;
                    idx_d   = 3'd4;
                    state_d = ST_FETCH;
                end
            end
            ST_MARK: begin
                sig_d = 1'b1;
                if (tmr_expired) begin
                    sig_d = 1'b0;
                    sh_d  = {sh_q[7:0], 2'b00};
                    if (idx_q != 3'd0) begin
                        idx_d = idx_q - 3'd1;
                    end
                    if (has_mark({sh_q[7:0], 2'b00})) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                        state_d  = ST_GAP;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                sig_d = 1'b0;
            end
            ST_DONE: begin
                sig_d   = 1'b0;
                state_d = ST_IDLE;
            end
            ST_FETCH: begin
                sig_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fetch_now) begin
            case (sh_q[9:8])
                MORSE_DOT: begin
                    tmr_load = 1'b1;
                    tmr_val  = DOT_LD;
                    sig_d    = 1'b1;
                    state_d  = ST_MARK;
                end
                MORSE_LINE: begin
                    tmr_load = 1'b1;
                    tmr_val  = LINE_LD;
                    sig_d    = 1'b1;
                    state_d  = ST_MARK;
                end
                default: begin
                    sh_d = {sh_q[7:0], 2'b00};
                    if (idx_q == 3'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        state_d = ST_FETCH;
                    end
                end
            endcase
        end
    end

    // State and output registers; busy/done follow the upcoming state.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.signal_out = sig_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Directed bench for morse_transmitter with short tick counts
// (DOT=2, LINE=6, GAP=2). Traces hold outputs sampled after each edge,
// bit n = value after the n-th edge following the start edge.
module tb_morse_transmitter;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    logic [63:0] cap_sig;
    logic [63:0] cap_done;
    logic [63:0] cap_busy;

    morse_transmitter_if bus_if ();

    morse_transmitter #(
        .DOT_TICKS  (2),
        .LINE_TICKS (6),
        .GAP_TICKS  (2),
        .CNT_W      (4)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Start a word, then record n samples; optional start poke and reset
    // poke at given sample indices (-1 disables).
    task automatic run_word(input logic [9:0] c, input int n,
                            input int poke_at, input logic [9:0] poke_code,
                            input int rst_at);
        cap_sig  = '0;
        cap_done = '0;
        cap_busy = '0;
        @(negedge clk);
        bus_if.code  = c;
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_sig[i]  = bus_if.signal_out;
            cap_done[i] = bus_if.done;
            cap_busy[i] = bus_if.busy;
            bus_if.start = 1'b0;
            if (i == poke_at) begin
                bus_if.code  = poke_code;
                bus_if.start = 1'b1;
            end
            resetn = (i == rst_at);
        end
        bus_if.start = 1'b0;
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.start = 1'b0;
        bus_if.code  = '0;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        cap_sig  = '0;
        cap_done = '0;
        cap_busy = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cap_sig[i]  = bus_if.signal_out;
            cap_done[i] = bus_if.done;
            cap_busy[i] = bus_if.busy;
        end
        total++;
        if (cap_sig !== 64'h0) begin
            bad++; $display("FAIL reset_sig got=%h want=%h", cap_sig, 64'h0);
        end
        total++;
        if (cap_done !== 64'h0) begin
            bad++; $display("FAIL reset_done got=%h want=%h", cap_done, 64'h0);
        end
        total++;
        if (cap_busy !== 64'h0) begin
            bad++; $display("FAIL reset_busy got=%h want=%h", cap_busy, 64'h0);
        end
    endtask

    task automatic test_dot_line();
        logic [63:0] es, ed, eb;
        run_word(10'b00_00_00_01_11, 20, -1, '0, -1);
        es = mask(4, 5) | mask(8, 13);
        ed = mask(14, 14);
        eb = mask(0, 14);
        total++;
        if (cap_sig !== es) begin
            bad++; $display("FAIL dotline_sig got=%h want=%h", cap_sig, es);
        end
        total++;
        if (cap_done !== ed) begin
            bad++; $display("FAIL dotline_done got=%h want=%h", cap_done, ed);
        end
        total++;
        if (cap_busy !== eb) begin
            bad++; $display("FAIL dotline_busy got=%h want=%h", cap_busy, eb);
        end
    endtask

    task automatic test_full_word(input string tag);
        logic [63:0] es, ed, eb;
        run_word(10'b11_01_01_11_01, 32, -1, '0, -1);
        es = mask(1, 6) | mask(9, 10) | mask(13, 14) | mask(17, 22) | mask(25, 26);
        ed = mask(27, 27);
        eb = mask(0, 27);
        total++;
        if (cap_sig !== es) begin
            bad++; $display("FAIL %s_sig got=%h want=%h", tag, cap_sig, es);
        end
        total++;
        if (cap_done !== ed) begin
            bad++; $display("FAIL %s_done got=%h want=%h", tag, cap_done, ed);
        end
        total++;
        if (cap_busy !== eb) begin
            bad++; $display("FAIL %s_busy got=%h want=%h", tag, cap_busy, eb);
        end
    endtask

    task automatic test_empty_invalid();
        logic [63:0] ed, eb;
        run_word(10'b00_00_00_00_00, 10, -1, '0, -1);
        ed = mask(5, 5);
        eb = mask(0, 5);
        total++;
        if (cap_sig !== 64'h0) begin
            bad++; $display("FAIL empty_sig got=%h want=%h", cap_sig, 64'h0);
        end
        total++;
        if (cap_done !== ed) begin
            bad++; $display("FAIL empty_done got=%h want=%h", cap_done, ed);
        end
        total++;
        if (cap_busy !== eb) begin
            bad++; $display("FAIL empty_busy got=%h want=%h", cap_busy, eb);
        end
        run_word(10'b00_10_00_00_01, 12, -1, '0, -1);
        total++;
        if (cap_sig !== mask(5, 6)) begin
            bad++; $display("FAIL invalid_sig got=%h want=%h", cap_sig, mask(5, 6));
        end
        total++;
        if (cap_done !== mask(7, 7)) begin
            bad++; $display("FAIL invalid_done got=%h want=%h", cap_done, mask(7, 7));
        end
        total++;
        if (cap_busy !== mask(0, 7)) begin
            bad++; $display("FAIL invalid_busy got=%h want=%h", cap_busy, mask(0, 7));
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] es;
        // Start with an all-lines word is pulsed during the 6-cycle line.
        run_word(10'b00_00_00_01_11, 24, 10, 10'b11_11_11_11_11, -1);
        es = mask(4, 5) | mask(8, 13);
        total++;
        if (cap_sig !== es) begin
            bad++; $display("FAIL busystart_sig got=%h want=%h", cap_sig, es);
        end
        total++;
        if (cap_done !== mask(14, 14)) begin
            bad++; $display("FAIL busystart_done got=%h want=%h", cap_done, mask(14, 14));
        end
        total++;
        if (cap_busy !== mask(0, 14)) begin
            bad++; $display("FAIL busystart_busy got=%h want=%h", cap_busy, mask(0, 14));
        end
    endtask

    task automatic test_reset_mid_mark();
        // Reset is applied at the edge after sample 3, inside the first line.
        run_word(10'b11_01_01_11_01, 20, -1, '0, 3);
        total++;
        if (cap_sig !== mask(1, 3)) begin
            bad++; $display("FAIL rstmid_sig got=%h want=%h", cap_sig, mask(1, 3));
        end
        total++;
        if (cap_done !== 64'h0) begin
            bad++; $display("FAIL rstmid_done got=%h want=%h", cap_done, 64'h0);
        end
        total++;
        if (cap_busy !== mask(0, 3)) begin
            bad++; $display("FAIL rstmid_busy got=%h want=%h", cap_busy, mask(0, 3));
        end
        test_full_word("replay");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b1;
        bus_if.start = 1'b0;
        bus_if.code  = '0;
        test_reset();
        test_dot_line();
        test_full_word("full");
        test_empty_invalid();
        test_start_while_busy();
        test_reset_mid_mark();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
